// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide sequencer: operation codes,
// shared-ALU opcodes, sequencer states and the default datapath width.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NEG_A,
        ST_NEG_B,
        ST_ITER,
        ST_FIX_LO,
        ST_FIX_HI
    } state_t;

endpackage

// File: rtl/muldiv_alu_mux.sv
// Selects the shared-ALU operands and opcode for each sequencer state.
// Purely combinational; every input comes from registered sequencer state.
module muldiv_alu_mux
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  state_t           state,
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             neg_res,
    input  logic             sign_a,
    input  logic             lo_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_unsig
);

    always_comb begin
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = ALU_ADD;
        alu_unsig = 1'b1;
        case (state)
            ST_NEG_A: begin
                alu_b  = opa;
                alu_op = opa[WIDTH-1] ? ALU_SUB : ALU_ADD;
            end
            ST_NEG_B: begin
                alu_b  = opb;
                alu_op = opb[WIDTH-1] ? ALU_SUB : ALU_ADD;
            end
            ST_ITER: begin
                if (is_div) begin
                    alu_a  = {hi[WIDTH-2:0], lo[WIDTH-1]};
                    alu_b  = opb;
                    alu_op = ALU_SUB;
                end else begin
                    alu_a = hi;
                    alu_b = lo[0] ? opa : '0;
                end
            end
            ST_FIX_LO: begin
                alu_b  = lo;
                alu_op = neg_res ? ALU_SUB : ALU_ADD;
            end
            ST_FIX_HI: begin
                // 64-bit negate of a product: the high word takes the carry out of negating lo.
                if (!is_div && neg_res) begin
                    alu_a = ~hi;
                    alu_b = {{(WIDTH-1){1'b0}}, lo_zero};
                end else begin
                    alu_b  = hi;
                    alu_op = (is_div && sign_a) ? ALU_SUB : ALU_ADD;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer into HI/LO, borrowing the shared ALU.
// Optional MULDIV_ABORT_EN adds an abort input that flushes and restores HI/LO.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef MULDIV_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_unsig,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_compout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    state_t           state, state_n;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] hi_q, lo_q, opa, opb;
    logic [5:0]       cnt;
    logic             sign_a, sign_b, lo_zero;
    logic             done_q, done_n;
    logic             abort_hit;
    logic [WIDTH-1:0] div_s;
    logic             take, carry;

`ifdef MULDIV_ABORT_EN
    logic [WIDTH-1:0] hi_sh, lo_sh;
    assign abort_hit = abort && busy;
`else
    assign abort_hit = 1'b0;
`endif

    assign busy  = (state != ST_IDLE);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign div_s = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    assign take  = hi_q[WIDTH-1] | ~alu_compout;
    assign carry = (alu_out < hi_q);

    muldiv_alu_mux #(.WIDTH(WIDTH)) u_alu_mux (
        .state     (state),
        .is_div    (op_q[1]),
        .hi        (hi_q),
        .lo        (lo_q),
        .opa       (opa),
        .opb       (opb),
        .neg_res   (sign_a ^ sign_b),
        .sign_a    (sign_a),
        .lo_zero   (lo_zero),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_unsig (alu_unsig)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        case (state)
            ST_IDLE:   if (start) state_n = md_op[0] ? ST_ITER : ST_NEG_A;
            ST_NEG_A:  state_n = ST_NEG_B;
            ST_NEG_B:  state_n = ST_ITER;
            ST_ITER: begin
                if (cnt == LAST) begin
                    if (op_q[0]) begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = ST_FIX_LO;
                    end
                end
            end
            ST_FIX_LO: state_n = ST_FIX_HI;
            ST_FIX_HI: begin
                state_n = ST_IDLE;
                done_n  = 1'b1;
            end
            default:   state_n = ST_IDLE;
        endcase
        if (abort_hit) begin
            state_n = ST_IDLE;
            done_n  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opa     <= '0;
            opb     <= '0;
            cnt     <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            lo_zero <= 1'b0;
            done_q  <= 1'b0;
`ifdef MULDIV_ABORT_EN
            hi_sh   <= '0;
            lo_sh   <= '0;
`endif
        end else begin
            done_q <= done_n;
            if (abort_hit) begin
`ifdef MULDIV_ABORT_EN
                hi_q <= hi_sh;
                lo_q <= lo_sh;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            op_q   <= md_op;
                            opa    <= rs_val;
                            opb    <= rt_val;
                            sign_a <= 1'b0;
                            sign_b <= 1'b0;
                            cnt    <= '0;
`ifdef MULDIV_ABORT_EN
                            hi_sh  <= hi_q;
                            lo_sh  <= lo_q;
`endif
                            // Unsigned ops skip the magnitude steps and load the shift pair now.
                            if (md_op[0]) begin
                                hi_q <= '0;
                                lo_q <= md_op[1] ? rs_val : rt_val;
                            end
                        end else begin
                            if (hi_we) hi_q <= wdata;
                            if (lo_we) lo_q <= wdata;
                        end
                    end
                    ST_NEG_A: begin
                        opa    <= alu_out;
                        sign_a <= opa[WIDTH-1];
                    end
                    ST_NEG_B: begin
                        opb    <= alu_out;
                        sign_b <= opb[WIDTH-1];
                        hi_q   <= '0;
                        lo_q   <= op_q[1] ? opa : alu_out;
                    end
                    ST_ITER: begin
                        cnt <= cnt + 6'd1;
                        if (op_q[1]) begin
                            hi_q <= take ? alu_out : div_s;
                            lo_q <= {lo_q[WIDTH-2:0], take};
                        end else begin
                            hi_q <= {carry, alu_out[WIDTH-1:1]};
                            lo_q <= {alu_out[0], lo_q[WIDTH-1:1]};
                        end
                    end
                    ST_FIX_LO: begin
                        lo_q    <= alu_out;
                        lo_zero <= (lo_q == '0);
                    end
                    ST_FIX_HI: hi_q <= alu_out;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: models the shared ALU, applies a vector table, random
// operations against an arithmetic reference, and busy/reset/abort sequences.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   md_op = 2'b00;
    logic [W-1:0] rs_val = '0, rt_val = '0, wdata = '0;
    logic         hi_we = 1'b0, lo_we = 1'b0;
    logic [W-1:0] alu_a, alu_b, alu_out, hi, lo;
    logic [2:0]   alu_op;
    logic         alu_unsig, alu_compout, busy, done;
`ifdef MULDIV_ABORT_EN
    logic         abort = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef MULDIV_ABORT_EN
        .abort       (abort),
`endif
        .start       (start),
        .md_op       (md_op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_unsig   (alu_unsig),
        .alu_out     (alu_out),
        .alu_compout (alu_compout),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
    );

    // Shared integer ALU seen by the sequencer
    always_comb begin
        alu_out = '0;
        case (alu_op)
            3'b000:  alu_out = alu_a & alu_b;
            3'b001:  alu_out = alu_a | alu_b;
            3'b100:  alu_out = ~(alu_a | alu_b);
            3'b101:  alu_out = alu_a ^ alu_b;
            3'b010:  alu_out = alu_a + alu_b;
            3'b110:  alu_out = alu_a - alu_b;
            default: alu_out = '0;
        endcase
        alu_compout = alu_unsig ? (alu_a < alu_b) : ($signed(alu_a) < $signed(alu_b));
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void ref_md(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] eh, output logic [W-1:0] el);
        logic [63:0] p;
        longint      sa, sb, q, r;
        case (op)
            MD_MULT: begin
                p  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                eh = p[63:32];
                el = p[31:0];
            end
            MD_MULTU: begin
                p  = {32'b0, a} * {32'b0, b};
                eh = p[63:32];
                el = p[31:0];
            end
            MD_DIV: begin
                if (b == '0) begin
                    el = a[31] ? 32'h00000001 : 32'hFFFFFFFF;
                    eh = a;
                end else begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    el = q[31:0];
                    eh = r[31:0];
                end
            end
            default: begin
                if (b == '0) begin
                    el = 32'hFFFFFFFF;
                    eh = a;
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
        endcase
    endfunction

    // Launch one operation; lat is the cycle index (T+lat) in which done is seen.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic busy_ok);
        @(posedge clk); #1;
        md_op = op; rs_val = a; rt_val = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (busy) busy_ok = 1'b0;
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] rs;
        logic [W-1:0] rt;
        logic [W-1:0] ehi;
        logic [W-1:0] elo;
    } vec_t;

    vec_t vecs[10];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int           lat;
        logic         bok;
        logic [W-1:0] eh, el;
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;
        logic         saw_done;

        vecs[0] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{MD_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vecs[4] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{MD_DIV,   32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'h00000001};
        vecs[6] = '{MD_DIV,   32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vecs[7] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8] = '{MD_MULT,  32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[9] = '{MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;

        // MTHI / MTLO in idle
        @(posedge clk); #1;
        hi_we = 1'b1; wdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5A5A0001;
        @(posedge clk); #1;
        lo_we = 1'b0;
        check("mthi", 64'(hi), 64'hA5A5A5A5);
        check("mtlo", 64'(lo), 64'h5A5A0001);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, lat, bok);
            check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].ehi));
            check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].elo));
            check($sformatf("vec%0d_latency", i), 64'(lat), vecs[i].op[0] ? 64'd33 : 64'd37);
            check($sformatf("vec%0d_busy", i), 64'(bok), 64'd1);
        end

        // Randomized operations against the arithmetic reference
        for (int i = 0; i < 60; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
            ref_md(rop, ra, rb, eh, el);
            run_op(rop, ra, rb, lat, bok);
            check($sformatf("rnd%0d_op%0d_hi", i, rop), 64'(hi), 64'(eh));
            check($sformatf("rnd%0d_op%0d_lo", i, rop), 64'(lo), 64'(el));
            check($sformatf("rnd%0d_latency", i), 64'(lat), rop[0] ? 64'd33 : 64'd37);
        end

        // start + MTHI together in idle (start wins), then start/MTHI/MTLO while busy
        @(posedge clk); #1;
        md_op = MD_MULTU; rs_val = 32'd5; rt_val = 32'd6; start = 1'b1;
        hi_we = 1'b1; wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            if (lat == 10) begin
                start = 1'b1; md_op = MD_DIV; rs_val = 32'd1; rt_val = 32'd1;
                hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFEF00D;
            end else begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        check("busy_ignore_latency", 64'(lat), 64'd33);
        check("busy_ignore_hi", 64'(hi), 64'd0);
        check("busy_ignore_lo", 64'(lo), 64'h1E);
        @(posedge clk); #1;
        check("busy_ignore_idle_after", 64'(busy), 64'd0);

        // Asynchronous reset in ITER cycle 10
        @(posedge clk); #1;
        md_op = MD_MULTU; rs_val = 32'hFFFFFFFF; rt_val = 32'hFFFFFFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("pre_reset_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midop_reset_busy", 64'(busy), 64'd0);
        check("midop_reset_hi", 64'(hi), 64'd0);
        check("midop_reset_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("midop_reset_no_resume", 64'(saw_done), 64'd0);

`ifdef MULDIV_ABORT_EN
        // Abort restores pre-start HI/LO and suppresses done
        @(posedge clk); #1;
        hi_we = 1'b1; wdata = 32'h00005555;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h00001234;
        @(posedge clk); #1;
        lo_we = 1'b0;
        md_op = MD_MULTU; rs_val = 32'd3; rt_val = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_lo", 64'(lo), 64'h00001234);
        check("abort_hi", 64'(hi), 64'h00005555);
        saw_done = 1'b0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);
        run_op(MD_MULT, 32'hFFFFFFFE, 32'h00000003, lat, bok);
        check("post_abort_lo", 64'(lo), 64'hFFFFFFFA);
        check("post_abort_hi", 64'(hi), 64'hFFFFFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer for the integer pipeline. Executes MULT, MULTU, DIV and DIVU into the architectural HI/LO registers.
- Owns no adder. Every add, subtract, negate and compare is issued to the shared 32-bit ALU (op encodings: 000 and, 001 or, 100 nor, 101 xor, 010 add, 110 sub; compout = a<b, honouring unsig).
- Sits beside the execute stage. The pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch operation; accepted only in IDLE
- md_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_val  in  WIDTH  multiplicand / dividend
- rt_val  in  WIDTH  multiplier / divisor
- hi_we, lo_we  in  1  MTHI/MTLO write strobes; honoured only when not busy
- wdata  in  WIDTH  MTHI/MTLO data
- alu_a, alu_b  out  WIDTH  ALU operands
- alu_op  out  3  ALU opcode
- alu_unsig  out  1  ALU unsigned select
- alu_out  in  WIDTH  ALU result, consumed in the same cycle
- alu_compout  in  1  ALU a<b flag
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; hi/lo valid
- hi, lo  out  WIDTH  HI/LO registers

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, hi=0, lo=0; internal registers cleared. Reset mid-operation abandons it; no partial result is kept.
- ALU drive: alu_* are combinational from registered state. In IDLE they drive add, a=0, b=0, unsig=1.
- States: IDLE, NEG_A, NEG_B, ITER, FIX_LO, FIX_HI.
- IDLE, start=1:
  - Latch md_op, rs, rt; clear sign flags.
  - Signed op → NEG_A. Unsigned op → ITER, with lo=rs (MUL multiplier=rt in lo, multiplicand=rs) and hi=0.
  - start ignored when busy.
- NEG_A / NEG_B: ALU computes 0−x if x negative, else 0+x (op 110/010, unsig=1). The result replaces the operand with its magnitude. Record sign_a/sign_b.
- ITER runs exactly WIDTH cycles; the count is in a 6-bit counter.
- MUL iteration:
  - a=hi, b = lo[0] ? mcand : 0, op add, unsig=1.
  - carry = (alu_out < hi), compared unsigned locally.
  - hi ← {carry, alu_out[31:1]}; lo ← {alu_out[0], lo[31:1]}.
- DIV iteration:
  - s = {hi[30:0], lo[31]}, top = hi[31]; a=s, b=divisor, op sub, unsig=1.
  - take = top | ~alu_compout.
  - hi ← take ? alu_out : s; lo ← {lo[30:0], take}.
- After ITER: signed → FIX_LO; unsigned → done.
- FIX_LO:
  - MUL: lo ← 0−lo if sign_a^sign_b.
  - DIV: lo ← 0−lo if sign_a^sign_b (quotient).
  - Record lo_zero = (pre-fix lo==0).
- FIX_HI:
  - MUL: hi ← ~hi + lo_zero if sign_a^sign_b.
  - DIV: hi ← 0−hi if sign_a (remainder).
  - No fix required → ALU passes the value through with add 0.
- Latency, start accepted at cycle T: done pulses at T+33 for unsigned ops and T+37 for signed ops. busy is high T+1 through done−1 and low in the done cycle. The next start may be accepted in the done cycle.
- Divide by zero is deterministic:
  - DIVU: lo=FFFFFFFF, hi=rs.
  - DIV: lo = rs<0 ? 00000001 : FFFFFFFF, hi=rs.
- hi_we/lo_we while busy are ignored. If asserted with start in IDLE, start wins.

Optional Feature:
- MULDIV_ABORT_EN: adds input abort (1 bit), used for the exception flush.
  - Defined: abort=1 while busy returns to IDLE next cycle. hi/lo are restored to their pre-start values, held in shadow registers. No done pulse.
  - Undefined: the port, the shadow registers and the logic are absent.

Decomposition:
- muldiv_pkg: md_op codes, ALU op constants (ALU_AND/OR/NOR/XOR/ADD/SUB), state enum, WIDTH default.
- One sub-module, muldiv_alu_mux: combinational selection of alu_a/alu_b/alu_op/alu_unsig from state and operands.

Test Plan:
- MULTU FFFFFFFF×FFFFFFFF → hi=FFFFFFFE, lo=00000001, done at T+33.
- MULT −3×7 (FFFFFFFD, 00000007) → hi=FFFFFFFF, lo=FFFFFFEB, done at T+37.
- DIV −7/2 → lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU 0x64/0 → lo=FFFFFFFF, hi=00000064.
- DIV 0x80000000/FFFFFFFF → lo=80000000, hi=0.
- start and MTHI pulsed while busy → ignored, result unchanged.
- rst_n low at ITER cycle 10 → busy=0, hi=lo=0 immediately.
- With MULDIV_ABORT_EN: MTLO 0x1234, then MULTU, abort at cycle 5 → lo=00001234, no done.
